switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer_pkg.sv | 19 +
 rtl/debounce_bit.sv | 94 +++++++++
 rtl/switch_debouncer.sv | 37 +++
 tb/tb_switch_debouncer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants, counter sizing and per-bit state encoding for the switch debouncer.
package switch_debouncer_pkg;

   localparam int N_SW_DEF          = 3;
   localparam int SYNC_STAGES_DEF   = 2;
   localparam int STABLE_CYCLES_DEF = 1000000;
   localparam int STABLE_CYCLES_SIM = 4;

   // Width of a counter that must hold values up to stable_cycles-1.
   function automatic int cnt_width(input int stable_cycles);
      return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
   endfunction

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: synchroniser, stability counter FSM and registered edge pulses.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_STABLE | synchronised input equals sw_db, counter idle at 0
//   ST_COUNT  | input differs from sw_db, counting consecutive samples
module debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int             CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   db_state_e              r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_db, w_db_nxt;
   logic                   r_rise, w_rise_nxt;
   logic                   r_fall, w_fall_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Shift the asynchronous pin through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
   end

   // State, counter, debounced level and edge pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // Next-state: accept a new level only after STABLE_CYCLES matching samples.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_db_nxt    = r_db;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         ST_STABLE: begin
            if (w_s != r_db) begin
               w_state_nxt = ST_COUNT;
               w_cnt_nxt   = CW'(1);
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         ST_COUNT: begin
            if (w_s == r_db) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
               w_db_nxt    = w_s;
               w_rise_nxt  = w_s;
               w_fall_nxt  = ~w_s;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
      endcase
   end

   assign sw_db   = r_db;
   assign sw_rise = r_rise;
   assign sw_fall = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW raw slide switches into clean levels plus rise/fall pulses.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int N_SW          = N_SW_DEF,
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] sw_raw,
   output logic [N_SW-1:0] sw_db,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic            sw_changed
);

   logic [N_SW-1:0] w_pulse;

   for (genvar g = 0; g < N_SW; g++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .sw_raw  (sw_raw[g]),
         .sw_db   (sw_db[g]),
         .sw_rise (sw_rise[g]),
         .sw_fall (sw_fall[g])
      );
   end

   assign w_pulse    = sw_rise | sw_fall;
   assign sw_changed = |w_pulse;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with short debounce interval: scoreboard of expected change events.
module tb_switch_debouncer;
   import switch_debouncer_pkg::*;

   localparam int LAT = 2 + STABLE_CYCLES_SIM;

   typedef struct {
      logic [2:0] db;
      logic [2:0] rise;
      logic [2:0] fall;
      int         t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw_raw = 3'b111;
   logic [2:0] sw_db, sw_rise, sw_fall;
   logic       sw_changed;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t q[$];
   logic [2:0] prev_db = 3'b000;

   switch_debouncer #(
      .N_SW          (3),
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (STABLE_CYCLES_SIM)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw),
      .sw_db      (sw_db),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] db,
                        input logic [2:0] rise, input logic [2:0] fall);
      exp_t e;
      sw_raw = v;
      e.db = db; e.rise = rise; e.fall = fall; e.t = cyc + LAT;
      q.push_back(e);
   endtask

   // Monitor: every change event must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_db = sw_db;
      end else begin
         if (sw_db !== prev_db) chk("db_change_has_pulse", int'(sw_changed), 1);
         if (sw_changed !== 1'b0) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse_db", int'(sw_db), int'(prev_db));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("event_time", cyc, e.t);
               chk("event_db", int'(sw_db), int'(e.db));
               chk("event_rise", int'(sw_rise), int'(e.rise));
               chk("event_fall", int'(sw_fall), int'(e.fall));
            end
         end
         prev_db = sw_db;
      end
   end

   initial begin
      // Reset with all switches high
      step(3);
      #1;
      chk("rst_db", int'(sw_db), 0);
      chk("rst_rise", int'(sw_rise), 0);
      chk("rst_fall", int'(sw_fall), 0);
      chk("rst_changed", int'(sw_changed), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b111, 3'b111, 3'b111, 3'b000);
      step(10);

      // Back to zero via reset, then clean step on bit0
      rst_n = 1'b0;
      sw_raw = 3'b000;
      step(2);
      rst_n = 1'b1;
      step(2);
      drive(3'b001, 3'b001, 3'b001, 3'b000);
      step(10);

      // Bounce on bit1: runs of 3 are rejected
      sw_raw = 3'b011; step(3);
      sw_raw = 3'b001; step(1);
      sw_raw = 3'b011; step(3);
      sw_raw = 3'b001; step(8);
      chk("bounce_db", int'(sw_db), 3'b001);
      drive(3'b011, 3'b011, 3'b010, 3'b000);
      step(8);
      chk("held_db", int'(sw_db), 3'b011);
      step(2);

      // Falling edge on bit2
      drive(3'b111, 3'b111, 3'b100, 3'b000);
      step(10);
      drive(3'b011, 3'b011, 3'b000, 3'b100);
      step(10);

      // Reset mid-count on bit2: interval restarts after release
      sw_raw = 3'b111;
      step(3);
      rst_n = 1'b0;
      #1;
      chk("midrst_db", int'(sw_db), 0);
      chk("midrst_changed", int'(sw_changed), 0);
      step(2);
      rst_n = 1'b1;
      drive(3'b111, 3'b111, 3'b111, 3'b000);
      step(LAT - 1);
      #1;
      chk("midrst_not_early", int'(sw_db), 0);
      step(6);

      // Mixed simultaneous rise and fall
      drive(3'b010, 3'b010, 3'b000, 3'b101);
      step(10);
      drive(3'b101, 3'b101, 3'b101, 3'b010);
      step(10);
      chk("final_db", int'(sw_db), 3'b101);

      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("missing_event_time", -1, e.t);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
